// File: rtl/psc_sched_pkg.sv
// Shared types and default widths for the prescaled timer scheduler.
package psc_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_PSC_W   = 5;
  localparam int DEF_CNT_W   = 8;
endpackage

// File: rtl/psc_tick_core.sv
// Prescaler counter: emits one tick every psc+1 enabled cycles.
module psc_tick_core
  import psc_sched_pkg::*;
#(
  parameter int PSC_W = DEF_PSC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] pcount;

  assign tick = en && (pcount == psc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcount <= '0;
    end else if (clr) begin
      pcount <= '0;
    end else if (en) begin
      pcount <= tick ? '0 : pcount + 1'b1;
    end
  end

endmodule

// File: rtl/psc_timer_sched.sv
// Round-robin scheduler sharing one prescaler tick generator among NUM_REQ
// requesters; each grant runs cnt ticks of period psc+1 and pulses done.
module psc_timer_sched
  import psc_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PSC_W   = DEF_PSC_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*PSC_W-1:0]   req_psc,
  input  logic [NUM_REQ*CNT_W-1:0]   req_cnt,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       tick
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, active_id_q, win, id_inc;
  logic             found, aborted, tick_i;
  logic [PSC_W-1:0] psc_q;
  logic [CNT_W-1:0] cnt_q, remain;
  logic [NUM_REQ-1:0] onehot;

  logic [PSC_W-1:0] psc_arr [NUM_REQ];
  logic [CNT_W-1:0] cnt_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign psc_arr[i] = req_psc[i*PSC_W +: PSC_W];
    assign cnt_arr[i] = req_cnt[i*CNT_W +: CNT_W];
  end

  // Arbiter: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign aborted = !req[active_id_q];
  assign id_inc  = (active_id_q == ID_W'(NUM_REQ-1)) ? '0 : active_id_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found) state_nxt = LOAD;
      LOAD: begin
        if (aborted)           state_nxt = IDLE;
        else if (cnt_q == '0)  state_nxt = DONE;
        else                   state_nxt = RUN;
      end
      RUN: begin
        if (aborted)                                state_nxt = IDLE;
        else if (tick_i && remain == CNT_W'(1))     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, remaining-tick counter and fairness pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_id_q <= '0;
      psc_q       <= '0;
      cnt_q       <= '0;
      remain      <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            active_id_q <= win;
            psc_q       <= psc_arr[win];
            cnt_q       <= cnt_arr[win];
          end
        end
        LOAD: remain <= cnt_q;
        RUN: begin
          // The final tick leaves remain at 1 rather than wrapping to 0.
          if (tick_i && remain != CNT_W'(1)) remain <= remain - 1'b1;
        end
        default: ;
      endcase
      if (state == DONE || ((state == LOAD || state == RUN) && aborted))
        rr_ptr <= id_inc;
    end
  end

  psc_tick_core #(
    .PSC_W (PSC_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LOAD),
    .en    (state == RUN),
    .psc   (psc_q),
    .tick  (tick_i)
  );

  assign onehot    = NUM_REQ'(1) << active_id_q;
  assign gnt       = (state == LOAD || state == RUN) ? onehot : '0;
  assign done      = (state == DONE) ? onehot : '0;
  assign busy      = (state != IDLE);
  assign active_id = active_id_q;
  assign tick      = tick_i;

endmodule

// File: tb/tb_psc_timer_sched.sv
// Directed bench for psc_timer_sched with a grant-timeline reference model.
module tb_psc_timer_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] req_psc;
  logic [31:0] req_cnt;
  logic [3:0]  gnt, done;
  logic        busy, tick;
  logic [1:0]  active_id;

  int checks = 0;
  int failures = 0;

  psc_timer_sched #(.NUM_REQ(4), .PSC_W(5), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_psc   (req_psc),
    .req_cnt   (req_cnt),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: each grant is a timeline measured in edges k since the granting edge.
  int m_phase = 0;  // 0 idle, 1 granted (LOAD/RUN), 2 done cycle
  int m_id = 0, m_rr = 0, m_psc = 0, m_cnt = 0, m_k = 0;

  function automatic int pick(input int rr, input logic [3:0] r);
    for (int j = 0; j < 4; j++)
      if (r[(rr + j) % 4]) return (rr + j) % 4;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_id = 0; m_rr = 0; m_psc = 0; m_cnt = 0; m_k = 0;
    end else begin
      case (m_phase)
        0: if (req != 4'b0) begin
          m_id    = pick(m_rr, req);
          m_psc   = int'(req_psc[m_id*5 +: 5]);
          m_cnt   = int'(req_cnt[m_id*8 +: 8]);
          m_k     = 0;
          m_phase = 1;
        end
        1: begin
          m_k++;
          if (!req[m_id]) begin
            m_phase = 0;
            m_rr    = (m_id + 1) % 4;
          end else if (m_k == 1 + m_cnt * (m_psc + 1)) begin
            m_phase = 2;
          end
        end
        default: begin
          m_phase = 0;
          m_rr    = (m_id + 1) % 4;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int eg, ed, et;
    eg = (m_phase == 1) ? (1 << m_id) : 0;
    ed = (m_phase == 2) ? (1 << m_id) : 0;
    et = (m_phase == 1 && m_k >= 1 && (m_k % (m_psc + 1)) == 0) ? 1 : 0;
    chk("cyc_gnt", int'(gnt), eg);
    chk("cyc_done", int'(done), ed);
    chk("cyc_busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("cyc_active_id", int'(active_id), m_id);
    chk("cyc_tick", int'(tick), et);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int id, input int psc, input int cnt);
    req_psc[id*5 +: 5] = psc[4:0];
    req_cnt[id*8 +: 8] = cnt[7:0];
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Follows one grant from the cycle after its granting edge until idle.
  task automatic watch(input int id, input int maxk, input int mut_k,
                       output int nt, output int t1, output int t2,
                       output int dk, output int ik);
    nt = 0; t1 = -1; t2 = -1; dk = -1; ik = -1;
    for (int k = 1; k <= maxk; k++) begin
      step();
      if (k == mut_k) req_psc[id*5 +: 5] = 5'd31;
      if (tick) begin
        nt++;
        if (nt == 1) t1 = k;
        if (nt == 2) t2 = k;
      end
      if (done[id] && dk < 0) begin
        dk = k;
        req[id] = 1'b0;
      end
      if (dk >= 0 && !busy && ik < 0) begin
        ik = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int nt, t1, t2, dk, ik, ntk, gcount, dcount;
    int gord[5];
    int dord[5];
    int exp_ord[5];
    bit saw_done;
    logic [3:0] prev_gnt;
    exp_ord = '{0, 1, 2, 3, 0};

    reset = 1'b0; req = '0; req_psc = '0; req_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_active_id", int'(active_id), 0);
    chk("rst_tick", int'(tick), 0);
    reset = 1'b1;
    step();

    // Single request on index 1: psc=2, cnt=3.
    load(1, 2, 3);
    req = 4'b0010;
    step();
    chk("single_gnt_e0", int'(gnt), 2);
    chk("single_busy_e0", int'(busy), 1);
    watch(1, 30, 0, nt, t1, t2, dk, ik);
    chk("single_ticks", nt, 3);
    chk("single_tick1", t1, 3);
    chk("single_tick2", t2, 6);
    chk("single_done_k", dk, 10);
    chk("single_idle_k", ik, 11);

    // Latched prescale: psc changed to 31 mid-run must be ignored.
    load(0, 1, 4);
    req = 4'b0001;
    step();
    chk("stab_gnt_e0", int'(gnt), 1);
    watch(0, 30, 2, nt, t1, t2, dk, ik);
    chk("stab_ticks", nt, 4);
    chk("stab_tick1", t1, 2);
    chk("stab_tick2", t2, 4);
    chk("stab_done_k", dk, 9);

    // Zero count: straight through LOAD to DONE, no tick.
    load(2, 31, 0);
    req = 4'b0100;
    step();
    chk("zero_gnt_e0", int'(gnt), 4);
    watch(2, 10, 0, nt, t1, t2, dk, ik);
    chk("zero_ticks", nt, 0);
    chk("zero_done_k", dk, 1);
    chk("zero_idle_k", ik, 2);

    // Reset asserted mid-run.
    load(1, 3, 5);
    req = 4'b0010;
    step();
    repeat (4) step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tick", int'(tick), 0);
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    chk("midrst_idle", int'(busy), 0);

    // Round-robin with all four requesters held.
    for (int i = 0; i < 4; i++) load(i, 0, 1);
    req = 4'b1111;
    prev_gnt = '0; gcount = 0; dcount = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (gnt != 4'b0 && prev_gnt == 4'b0 && gcount < 5) begin
        gord[gcount] = oh2i(gnt);
        gcount++;
      end
      prev_gnt = gnt;
      if (done != 4'b0 && dcount < 5) begin
        dord[dcount] = oh2i(done);
        dcount++;
        if (dcount == 5) begin
          req = '0;
          break;
        end
      end
    end
    chk("rr_grants", gcount, 5);
    chk("rr_dones", dcount, 5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", gord[i], exp_ord[i]);
      chk("rr_done_id", dord[i], exp_ord[i]);
    end

    // Abort of index 2 after two ticks; index 3 must win over index 0.
    step();
    load(2, 1, 5);
    load(3, 0, 2);
    load(0, 0, 1);
    req = 4'b1101;
    step();
    chk("abort_gnt_e0", int'(gnt), 4);
    ntk = 0; saw_done = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (tick) ntk++;
      if (done[2]) saw_done = 1'b1;
    end
    chk("abort_ticks_before", ntk, 2);
    req[2] = 1'b0;
    step();
    if (done[2]) saw_done = 1'b1;
    chk("abort_gnt_drop", int'(gnt), 0);
    chk("abort_no_done", int'(saw_done), 0);
    step();
    chk("abort_next_gnt", int'(gnt), 8);
    watch(3, 10, 0, nt, t1, t2, dk, ik);
    chk("after_abort_done_k", dk, 3);
    req = '0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
